// File: rtl/digit_draw.sv
// Glyph scanner for the score/time display: on a slot load it latches that slot's
// BCD digit and plots a 4x5 glyph, one pixel per cycle, then pulses drawDone.
module digit_draw #(
  parameter logic [7:0] SCORE_TEN_X = 8'd10,
  parameter logic [7:0] SCORE_ONE_X = 8'd15,
  parameter logic [7:0] TIME_TEN_X  = 8'd130,
  parameter logic [7:0] TIME_ONE_X  = 8'd135,
  parameter logic [6:0] DIGIT_Y     = 7'd4,
  parameter logic [2:0] FG_COLOUR   = 3'b111,
  parameter logic [2:0] BG_COLOUR   = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ld_scoreTen,
  input  logic       ld_scoreOne,
  input  logic       ld_timeTen,
  input  logic       ld_timeOne,
  input  logic [3:0] scoreTen,
  input  logic [3:0] scoreOne,
  input  logic [3:0] timeTen,
  input  logic [3:0] timeOne,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       drawDone
);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  state_t     state_reg, state_next;
  logic [1:0] col_reg, col_next;
  logic [2:0] row_reg, row_next;
  logic [1:0] slot_reg, slot_next;
  logic [3:0] digit_reg, digit_next;
  logic [7:0] x_reg;
  logic [6:0] y_reg;
  logic [2:0] colour_reg;

  logic [7:0] slot_x;
  logic [3:0] row_bits;
  logic [7:0] pix_x;
  logic [6:0] pix_y;
  logic [2:0] pix_colour;

  // One nibble per row, top row in the high nibble, MSB is the leftmost pixel.
  function automatic logic [3:0] glyph(input logic [3:0] d, input logic [2:0] r);
    logic [19:0] g;
    g = 20'h0;
    case (d)
      4'd0: g = 20'hF999F;
      4'd1: g = 20'h26227;
      4'd2: g = 20'hF1F8F;
      4'd3: g = 20'hF171F;
      4'd4: g = 20'h99F11;
      4'd5: g = 20'hF8F1F;
      4'd6: g = 20'hF8F9F;
      4'd7: g = 20'hF1244;
      4'd8: g = 20'hF9F9F;
      4'd9: g = 20'hF9F1F;
      default: g = 20'h0;
    endcase
    case (r)
      3'd0: glyph = g[19:16];
      3'd1: glyph = g[15:12];
      3'd2: glyph = g[11:8];
      3'd3: glyph = g[7:4];
      3'd4: glyph = g[3:0];
      default: glyph = 4'h0;
    endcase
  endfunction

  always_comb begin
    case (slot_reg)
      2'd0: slot_x = SCORE_TEN_X;
      2'd1: slot_x = SCORE_ONE_X;
      2'd2: slot_x = TIME_TEN_X;
      default: slot_x = TIME_ONE_X;
    endcase
    row_bits   = glyph(digit_reg, row_reg);
    pix_x      = slot_x + {6'd0, col_reg};
    pix_y      = DIGIT_Y + {4'd0, row_reg};
    pix_colour = row_bits[2'd3 - col_reg] ? FG_COLOUR : BG_COLOUR;
  end

  always_comb begin
    state_next = state_reg;
    col_next   = col_reg;
    row_next   = row_reg;
    slot_next  = slot_reg;
    digit_next = digit_reg;
    case (state_reg)
      IDLE: begin
        if (ld_scoreTen | ld_scoreOne | ld_timeTen | ld_timeOne) begin
          state_next = DRAW;
          col_next   = 2'd0;
          row_next   = 3'd0;
          // Fixed priority; the losing requests are simply dropped.
          if (ld_scoreTen) begin
            slot_next  = 2'd0;
            digit_next = scoreTen;
          end else if (ld_scoreOne) begin
            slot_next  = 2'd1;
            digit_next = scoreOne;
          end else if (ld_timeTen) begin
            slot_next  = 2'd2;
            digit_next = timeTen;
          end else begin
            slot_next  = 2'd3;
            digit_next = timeOne;
          end
        end
      end
      DRAW: begin
        if (col_reg == 2'd3) begin
          col_next = 2'd0;
          if (row_reg == 3'd4) begin
            row_next   = 3'd0;
            state_next = DONE;
          end else begin
            row_next = row_reg + 3'd1;
          end
        end else begin
          col_next = col_reg + 2'd1;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg  <= IDLE;
      col_reg    <= 2'd0;
      row_reg    <= 3'd0;
      slot_reg   <= 2'd0;
      digit_reg  <= 4'd0;
      x_reg      <= 8'd0;
      y_reg      <= 7'd0;
      colour_reg <= BG_COLOUR;
    end else begin
      state_reg <= state_next;
      col_reg   <= col_next;
      row_reg   <= row_next;
      slot_reg  <= slot_next;
      digit_reg <= digit_next;
      // Remember the last plotted pixel so the bus holds still between scans.
      if (state_reg == DRAW) begin
        x_reg      <= pix_x;
        y_reg      <= pix_y;
        colour_reg <= pix_colour;
      end
    end
  end

  assign plot     = (state_reg == DRAW);
  assign drawDone = (state_reg == DONE);
  assign x        = plot ? pix_x : x_reg;
  assign y        = plot ? pix_y : y_reg;
  assign colour   = plot ? pix_colour : colour_reg;

endmodule

// File: doc/digit_draw.md
Name: digit_draw

Overview:
- Drawing responder for the score/time display sequencer.
- Accepts one-cycle load pulses for the four display slots: score tens, score ones, time tens, time ones.
- On a load, latches that slot's BCD digit and scans a 4x5 glyph into the VGA pixel interface, one pixel per cycle.
- When the scan finishes, returns a one-cycle drawDone pulse so the sequencer can advance to the next slot.

Parameters:
- SCORE_TEN_X, 8'd10: left x of score tens glyph
- SCORE_ONE_X, 8'd15: left x of score ones glyph
- TIME_TEN_X, 8'd130: left x of time tens glyph
- TIME_ONE_X, 8'd135: left x of time ones glyph
- DIGIT_Y, 7'd4: top y of all glyphs
- FG_COLOUR, 3'b111: colour for set glyph bits
- BG_COLOUR, 3'b000: colour for clear glyph bits and blank digits

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low
- ld_scoreTen  in  1  one-cycle request to draw the score tens slot
- ld_scoreOne  in  1  one-cycle request to draw the score ones slot
- ld_timeTen  in  1  one-cycle request to draw the time tens slot
- ld_timeOne  in  1  one-cycle request to draw the time ones slot
- scoreTen  in  4  BCD digit
- scoreOne  in  4  BCD digit
- timeTen  in  4  BCD digit
- timeOne  in  4  BCD digit
- x  out  8  pixel x to VGA adapter
- y  out  7  pixel y to VGA adapter
- colour  out  3  pixel colour
- plot  out  1  pixel write enable
- drawDone  out  1  one-cycle completion pulse

Behaviour:
- Reset:
  - Sampled on posedge clk while reset==0.
  - State goes to IDLE; col, row, slot and digit registers clear.
  - Outputs: plot=0, drawDone=0, x=0, y=0, colour=BG_COLOUR.
  - Reset during DRAW or DONE aborts the scan; no drawDone is issued.
- States: IDLE, DRAW, DONE.
- IDLE:
  - On an edge where any ld_* is 1: latch the slot and that slot's digit input, clear col/row, go to DRAW.
  - Simultaneous ld_* resolve by priority scoreTen > scoreOne > timeTen > timeOne; the lower-priority requests are dropped.
- DRAW:
  - plot=1 every cycle.
  - x = slot_x + col and y = DIGIT_Y + row, each truncated to port width.
  - colour = FG_COLOUR if glyph[digit][row][3-col] is set, else BG_COLOUR.
  - Scan order is row-major: col 0..3 inner, row 0..4 outer.
  - After col=3,row=4, go to DONE.
  - Exactly 20 plot cycles per request.
- DONE: drawDone=1, plot=0 for exactly one cycle, then IDLE.
- Timing from the edge where ld is sampled (call it edge 0):
  - plot high in the cycles following edges 0..19.
  - drawDone high in the cycle following edge 20.
  - drawDone is never asserted in the cycle after the ld pulse; the sequencer passes through a one-cycle non-wait state before it samples drawDone.
- ld_* asserted while in DRAW or DONE is ignored and not queued. The sequencer never does this; the bench checks it explicitly.
- Digits are latched at the load edge, so input changes during the scan do not affect the glyph.
- Digit values 10..15 draw a blank glyph: all 20 pixels are BG_COLOUR and still plotted, and drawDone is still issued.
- Outside DRAW: plot=0 and x, y, colour hold their last values; consumers use them only when plot=1.
- Glyph ROM: rows top to bottom, hex nibble per row, MSB = leftmost column.
  - 0: F,9,9,9,F
  - 1: 2,6,2,2,7
  - 2: F,1,F,8,F
  - 3: F,1,7,1,F
  - 4: 9,9,F,1,1
  - 5: F,8,F,1,F
  - 6: F,8,F,9,F
  - 7: F,1,2,4,4
  - 8: F,9,F,9,F
  - 9: F,9,F,1,F

Test Plan:
- Reset low 2 cycles, then high; no ld -> plot=0 and drawDone=0 indefinitely.
- scoreTen=4, pulse ld_scoreTen -> 20 plots:
  - first (x=10,y=4,colour=7), (11,4,0), (12,4,0), (13,4,7)
  - last (13,8,7)
  - drawDone exactly 21 cycles after the ld edge, one cycle wide.
- ld_timeOne and ld_scoreOne in the same cycle with timeOne=7, scoreOne=0 -> only the score ones slot is drawn: x spans 15..18, row 1 pattern 9 gives colours 7,0,0,7. One drawDone only.
- Full sequencer loop (score tens, time tens, score ones, time ones) with digits 1,2,3,9 -> four scans:
  - x bases 10, 130, 15, 135.
  - Glyph pixels match the ROM.
  - Four drawDone pulses.
- timeTen=12 -> 20 plots, all colour 0, then drawDone. Change timeTen mid-scan -> glyph unchanged.
- Assert reset at plot cycle 8 -> plot=0 next cycle and no drawDone. A later ld_timeTen starts a fresh scan at col=0,row=0.
